// File: rtl/keypad_calc_engine_if.sv
// Byte-stream input and display/status outputs of the keypad calculator engine.
// The master side feeds scancodes; the slave side is the engine itself.
interface keypad_calc_engine_if #(
    parameter int DIGITS = 6
);
    logic [7:0]          iBYTE;
    logic                iBYTE_VALID;
    logic [4*DIGITS-1:0] oDISP_BCD;
    logic                oNEG;
    logic                oERR;
    logic                oBUSY;
    logic                oREM_SHOWN;
    logic [2:0]          oSTATE;

    modport master (
        output iBYTE, iBYTE_VALID,
        input  oDISP_BCD, oNEG, oERR, oBUSY, oREM_SHOWN, oSTATE
    );

    modport slave (
        input  iBYTE, iBYTE_VALID,
        output oDISP_BCD, oNEG, oERR, oBUSY, oREM_SHOWN, oSTATE
    );
endinterface

// File: rtl/keypad_calc_engine.sv
// Scancode-driven BCD calculator: make/break filter, operand entry, sequential add/sub/mul/div, BCD result.
// Busy 2*DIGITS+1+W (add/sub) or 2*DIGITS+2*W (mul/div) cycles after Enter; make codes arriving while busy are dropped.
module keypad_calc_engine #(
    parameter int DIGITS = 6,
    parameter int W      = 24
) (
    input  logic                iCLK,
    input  logic                iRST,
    keypad_calc_engine_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);
    localparam logic [2*W-1:0] MAXV = (2*W)'(10**DIGITS - 1);

    // CONV_B shares the low three bits with CONV_A so oSTATE stays 3 bits wide
    localparam logic [3:0] S_IDLE = 4'd0, S_OPA = 4'd1, S_OPB = 4'd2, S_CONV_A = 4'd3,
                           S_EXEC = 4'd4, S_CONV_R = 4'd5, S_RESULT = 4'd6, S_ERROR = 4'd7,
                           S_CONV_B = 4'd11;
    localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;

    logic [3:0]    state;
    logic [BW-1:0] a_bcd, b_bcd, cvt_sh, res_bcd, rem_bcd;
    logic [W-1:0]  bin_a, bin_b, res_bin, rem_bin;
    logic [2*W-1:0] acc, acc_nxt, add_sum;
    logic [1:0]    op, key_op;
    logic [CW-1:0] cnt;
    logic          neg, rem_shown, brk, busy, make_vld;
    logic          is_dig, is_op, k_dig, k_op, k_enter, k_space, k_bksp, k_esc, do_clear;
    logic [3:0]    dig;

    function automatic logic [BW-1:0] push_digit(input logic [BW-1:0] v, input logic [3:0] d);
        logic [BW+3:0] t;
        t = {v, d};
        if (v[BW-1 -: 4] != 4'd0 || (v == '0 && d == 4'd0))
            return v;
        return t[BW-1:0];
    endfunction

    // One double-dabble iteration: add 3 to every nibble >= 5, then shift in the next binary bit
    function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] v, input logic b);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++)
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        return {r[BW-2:0], b};
    endfunction

    assign busy     = (state == S_CONV_A) || (state == S_CONV_B) || (state == S_EXEC) || (state == S_CONV_R);
    assign make_vld = bus.iBYTE_VALID && (bus.iBYTE != 8'hF0) && (bus.iBYTE != 8'hE0) && !brk && !busy;

    always_comb begin
        is_dig = 1'b1;
        dig    = 4'd0;
        case (bus.iBYTE)
            8'h70: dig = 4'd0;  8'h69: dig = 4'd1;  8'h72: dig = 4'd2;  8'h7A: dig = 4'd3;
            8'h6B: dig = 4'd4;  8'h73: dig = 4'd5;  8'h74: dig = 4'd6;  8'h6C: dig = 4'd7;
            8'h75: dig = 4'd8;  8'h7D: dig = 4'd9;
            default: is_dig = 1'b0;
        endcase
        is_op  = 1'b1;
        key_op = OP_ADD;
        case (bus.iBYTE)
            8'h79: key_op = OP_ADD;
            8'h7B: key_op = OP_SUB;
            8'h7C: key_op = OP_MUL;
            8'h4A: key_op = OP_DIV;
            default: is_op = 1'b0;
        endcase
    end

    assign k_dig    = make_vld && is_dig;
    assign k_op     = make_vld && is_op;
    assign k_enter  = make_vld && (bus.iBYTE == 8'h5A);
    assign k_space  = make_vld && (bus.iBYTE == 8'h29);
    assign k_bksp   = make_vld && (bus.iBYTE == 8'h66);
    assign k_esc    = make_vld && (bus.iBYTE == 8'h76);
    assign do_clear = k_esc || (k_enter && (state == S_RESULT || state == S_ERROR));

    // acc holds {partial product} for MUL and {remainder, quotient} for DIV
    logic [W:0]   msum, shifted;
    logic [W-1:0] diff, sub_mag, ex_q, ex_r;
    logic         a_lt, ex_last, ex_err, ex_neg;

    always_comb begin
        msum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, bin_b} : '0);
        shifted  = {acc[2*W-1:W], acc[W-1]};
        diff     = shifted[W-1:0] - bin_b;
        acc_nxt  = (op == OP_DIV)
                 ? ((shifted >= {1'b0, bin_b}) ? {diff, acc[W-2:0], 1'b1} : {shifted[W-1:0], acc[W-2:0], 1'b0})
                 : {msum, acc[W-1:1]};
        add_sum  = {{W{1'b0}}, bin_a} + {{W{1'b0}}, bin_b};
        a_lt     = bin_a < bin_b;
        sub_mag  = a_lt ? (bin_b - bin_a) : (bin_a - bin_b);
        ex_last  = 1'b1;
        ex_err   = 1'b0;
        ex_q     = '0;
        ex_r     = '0;
        ex_neg   = 1'b0;
        case (op)
            OP_ADD: begin ex_q = add_sum[W-1:0]; ex_err = add_sum > MAXV; end
            OP_SUB: begin ex_q = sub_mag; ex_neg = a_lt; end
            OP_MUL: begin
                ex_last = (cnt == CW'(W - 1));
                ex_err  = acc_nxt > MAXV;
                ex_q    = acc_nxt[W-1:0];
            end
            default: begin
                ex_last = (bin_b == '0) || (cnt == CW'(W - 1));
                ex_err  = (bin_b == '0);
                ex_q    = acc_nxt[W-1:0];
                ex_r    = acc_nxt[2*W-1:W];
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST)
            brk <= 1'b0;
        else if (bus.iBYTE_VALID) begin
            if (bus.iBYTE == 8'hF0)
                brk <= 1'b1;
            else if (bus.iBYTE != 8'hE0 && brk)
                brk <= 1'b0;
        end

        if (iRST || do_clear) begin
            state <= S_IDLE;  op <= OP_ADD;  neg <= 1'b0;  rem_shown <= 1'b0;
            a_bcd <= '0;  b_bcd <= '0;  cvt_sh <= '0;  res_bcd <= '0;  rem_bcd <= '0;
            bin_a <= '0;  bin_b <= '0;  res_bin <= '0;  rem_bin <= '0;  acc <= '0;  cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (k_dig) begin
                        a_bcd <= BW'(dig);
                        state <= S_OPA;
                    end else if (k_op) begin
                        a_bcd <= '0;  b_bcd <= '0;  op <= key_op;
                        state <= S_OPB;
                    end
                end
                S_OPA: begin
                    if (k_dig)       a_bcd <= push_digit(a_bcd, dig);
                    else if (k_bksp) a_bcd <= a_bcd >> 4;
                    else if (k_op) begin
                        op <= key_op;  b_bcd <= '0;
                        state <= S_OPB;
                    end
                end
                S_OPB: begin
                    if (k_dig)       b_bcd <= push_digit(b_bcd, dig);
                    else if (k_bksp) b_bcd <= b_bcd >> 4;
                    else if (k_op)   op <= key_op;
                    else if (k_enter) begin
                        cvt_sh <= a_bcd;  bin_a <= '0;  cnt <= '0;  rem_shown <= 1'b0;
                        state <= S_CONV_A;
                    end
                end
                S_CONV_A: begin
                    bin_a  <= (bin_a << 3) + (bin_a << 1) + W'(cvt_sh[BW-1 -: 4]);
                    cvt_sh <= cvt_sh << 4;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(DIGITS - 1)) begin
                        cvt_sh <= b_bcd;  bin_b <= '0;  cnt <= '0;
                        state  <= S_CONV_B;
                    end
                end
                S_CONV_B: begin
                    bin_b  <= (bin_b << 3) + (bin_b << 1) + W'(cvt_sh[BW-1 -: 4]);
                    cvt_sh <= cvt_sh << 4;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(DIGITS - 1)) begin
                        acc <= {{W{1'b0}}, bin_a};  cnt <= '0;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (ex_last) begin
                        if (ex_err)
                            state <= S_ERROR;
                        else begin
                            res_bin <= ex_q;  rem_bin <= ex_r;  neg <= ex_neg;
                            res_bcd <= '0;    rem_bcd <= '0;    cnt <= '0;
                            state   <= S_CONV_R;
                        end
                    end
                end
                S_CONV_R: begin
                    res_bcd <= dd_step(res_bcd, res_bin[W-1]);
                    rem_bcd <= dd_step(rem_bcd, rem_bin[W-1]);
                    res_bin <= res_bin << 1;
                    rem_bin <= rem_bin << 1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) state <= S_RESULT;
                end
                S_RESULT: begin
                    if (k_space) begin
                        if (op == OP_DIV) rem_shown <= ~rem_shown;
                    end else if (k_dig) begin
                        a_bcd <= BW'(dig);  neg <= 1'b0;  rem_shown <= 1'b0;
                        state <= S_OPA;
                    end else if (k_op && !neg) begin
                        a_bcd <= res_bcd;  b_bcd <= '0;  op <= key_op;  rem_shown <= 1'b0;
                        state <= S_OPB;
                    end
                end
                S_ERROR: ;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (state)
            S_IDLE, S_OPA: bus.oDISP_BCD = a_bcd;
            S_RESULT:      bus.oDISP_BCD = rem_shown ? rem_bcd : res_bcd;
            S_ERROR:       bus.oDISP_BCD = {DIGITS{4'hE}};
            default:       bus.oDISP_BCD = b_bcd;
        endcase
    end

    assign bus.oNEG       = (state == S_RESULT) && neg;
    assign bus.oERR       = (state == S_ERROR);
    assign bus.oBUSY      = busy;
    assign bus.oREM_SHOWN = (state == S_RESULT) && rem_shown;
    assign bus.oSTATE     = state[2:0];
endmodule

// File: tb/tb_keypad_calc_engine.sv
// Directed bench for keypad_calc_engine (DIGITS=6, W=24): vector table plus timing and corner sequences.
module tb_keypad_calc_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keypad_calc_engine_if #(.DIGITS(6)) bus ();
    keypad_calc_engine #(.DIGITS(6), .W(24)) dut (.iCLK(clk), .iRST(rst), .bus(bus));

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [127:0] seq;
        int           n;
        logic [23:0]  disp;
        logic         neg;
        logic         err;
        logic         rem;
        logic [2:0]   st;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic [127:0] s, input int n, input logic [23:0] d,
                                input logic ng, input logic er, input logic rm, input logic [2:0] st);
        vec_t v;
        v.seq = s; v.n = n; v.disp = d; v.neg = ng; v.err = er; v.rem = rm; v.st = st;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.iBYTE = b;
        bus.iBYTE_VALID = 1'b1;
        @(negedge clk);
        bus.iBYTE_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.oBUSY && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("busy_timeout", 32'(bus.oBUSY), 32'd0);
    endtask

    task automatic send_seq(input logic [127:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = s[8*(n-1-i) +: 8];
            send(b);
            wait_idle();
        end
    endtask

    task automatic check_out(input string nm, input logic [23:0] d, input logic ng,
                             input logic er, input logic rm, input logic [2:0] st);
        chk({nm, "_disp"}, 32'(bus.oDISP_BCD), 32'(d));
        chk({nm, "_neg"},  32'(bus.oNEG), 32'(ng));
        chk({nm, "_err"},  32'(bus.oERR), 32'(er));
        chk({nm, "_rem"},  32'(bus.oREM_SHOWN), 32'(rm));
        chk({nm, "_state"}, 32'(bus.oSTATE), 32'(st));
    endtask

    task automatic measure_busy(input string nm, input logic [127:0] s, input int n, input int exp);
        int cyc = 0;
        send(8'h76);
        send_seq(s, n);
        send(8'h5A);
        while (bus.oBUSY && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk(nm, 32'(cyc), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        bus.iBYTE = 8'h00;
        bus.iBYTE_VALID = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(bus.oBUSY), 32'd0);
        check_out("rst", 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0);

        // state codes: 0 IDLE, 1 OPA, 2 OPB, 6 RESULT, 7 ERROR
        add(128'h69727A796B73745A,         8, 24'h000579, 0, 0, 0, 3'd6);
        add(128'h737B69725A,               5, 24'h000007, 1, 0, 0, 3'd6);
        add(128'h737B69725A79,             6, 24'h000007, 1, 0, 0, 3'd6);
        add(128'h697070707C697070705A,    10, 24'hEEEEEE, 0, 1, 0, 3'd7);
        add(128'h697070707C697070705A76,  11, 24'h000000, 0, 0, 0, 3'd0);
        add(128'h697070E04A6C5A,           7, 24'h000014, 0, 0, 0, 3'd6);
        add(128'h697070E04A6C5A29,         8, 24'h000002, 0, 0, 1, 3'd6);
        add(128'h697070E04A6C5A2929,       9, 24'h000014, 0, 0, 0, 3'd6);
        add(128'h7D4A705A,                 4, 24'hEEEEEE, 0, 1, 0, 3'd7);
        add(128'h7D4A705A5A,               5, 24'h000000, 0, 0, 0, 3'd0);
        add(128'h69696969696969,           7, 24'h111111, 0, 0, 0, 3'd1);
        add(128'h69F06969F0696672,         8, 24'h000012, 0, 0, 0, 3'd1);
        add(128'h69F06969F069667279735A,  11, 24'h000017, 0, 0, 0, 3'd6);
        add(128'h7A70707C7A70705A,         8, 24'h090000, 0, 0, 0, 3'd6);
        add(128'h7D7D7D7D7D7D79695A,       9, 24'hEEEEEE, 0, 1, 0, 3'd7);
        add(128'h7D7D7D7D7D7D79705A,       9, 24'h999999, 0, 0, 0, 3'd6);
        add(128'h707069,                   3, 24'h000001, 0, 0, 0, 3'd1);
        add(128'h6966,                     2, 24'h000000, 0, 0, 0, 3'd1);
        add(128'h7A797B695A,               5, 24'h000002, 0, 0, 0, 3'd6);
        add(128'h695A,                     2, 24'h000001, 0, 0, 0, 3'd1);
        add(128'h6979695A6B,               5, 24'h000004, 0, 0, 0, 3'd1);
        add(128'h6979695A29,               5, 24'h000002, 0, 0, 0, 3'd6);
        add(128'h69727B,                   3, 24'h000000, 0, 0, 0, 3'd2);
        add(128'h697276,                   3, 24'h000000, 0, 0, 0, 3'd0);
        add(128'h697B735A79,               5, 24'h000004, 1, 0, 0, 3'd6);

        for (int i = 0; i < vecs.size(); i++) begin
            send(8'h76);
            send_seq(vecs[i].seq, vecs[i].n);
            check_out($sformatf("v%0d", i), vecs[i].disp, vecs[i].neg, vecs[i].err, vecs[i].rem, vecs[i].st);
        end

        measure_busy("busy_add", 128'h69727A796B7374, 7, 37);
        measure_busy("busy_sub", 128'h737B6972,       4, 37);
        measure_busy("busy_mul", 128'h7A70707C7A7070, 7, 60);
        measure_busy("busy_div", 128'h697070E04A6C,   6, 60);

        // Keys and a break prefix arriving during the busy window
        send(8'h76);
        send_seq(128'h6972797335, 0);
        send_seq(128'h69727973, 4);
        send(8'h5A);
        send(8'h72);
        send(8'h69);
        send(8'hF0);
        chk("drop_busy_still", 32'(bus.oBUSY), 32'd1);
        wait_idle();
        check_out("drop", 24'h000017, 1'b0, 1'b0, 1'b0, 3'd6);
        send(8'h69);
        check_out("brk_in_busy", 24'h000017, 1'b0, 1'b0, 1'b0, 3'd6);
        send(8'h69);
        check_out("after_brk", 24'h000001, 1'b0, 1'b0, 1'b0, 3'd1);

        // Reset aborts a calculation in progress
        send(8'h76);
        send_seq(128'h69727A796B7374, 7);
        send(8'h5A);
        repeat (5) @(negedge clk);
        chk("abort_busy_before", 32'(bus.oBUSY), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(bus.oBUSY), 32'd0);
        check_out("abort", 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0);

        // Reset wins over a same-cycle digit
        @(negedge clk);
        rst = 1'b1;
        bus.iBYTE = 8'h69;
        bus.iBYTE_VALID = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.iBYTE_VALID = 1'b0;
        check_out("rst_vs_byte", 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
